// File: rtl/fifo_link_tx.sv
// Transmit drain engine: pops flits from the output FIFO and forwards them onto
// the link under credit-based flow control, never exceeding downstream capacity.
module fifo_link_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CREDITS    = 4,
  localparam int unsigned CNT_W     = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  input  logic                  link_credit,
  output logic [CNT_W-1:0]      credit_count,
  output logic [15:0]           sent_count,
  output logic                  err_credit_ovf
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  logic                  pop_c;
  logic                  rd_pend_q, rd_pend_d;
  logic                  link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic [15:0]           sent_q, sent_d;
  logic                  ovf_q, ovf_d;

  // Pop only when a downstream slot is guaranteed; gated by rst so nothing
  // leaves the FIFO while the link side is held in reset.
  always_comb begin
    pop_c = rst & tx_en & ~fifo_empty & (credit_q != '0);
  end

  always_comb begin
    rd_pend_d    = pop_c;
    link_valid_d = rd_pend_q;
    link_data_d  = link_data_q;
    credit_d     = credit_q;
    sent_d       = sent_q;
    ovf_d        = ovf_q;

    if (rd_pend_q) begin
      link_data_d = fifo_rd_data;
    end

    if (link_valid_q) begin
      sent_d = sent_q + 16'd1;
    end

    // A pop and a returned credit in the same cycle cancel out.
    unique case ({pop_c, link_credit})
      2'b10: credit_d = credit_q - CNT_W'(1);
      2'b01: begin
        if (credit_q == CRED_MAX) begin
          ovf_d = 1'b1;
        end else begin
          credit_d = credit_q + CNT_W'(1);
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q    <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      credit_q     <= CRED_MAX;
      sent_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      credit_q     <= credit_d;
      sent_q       <= sent_d;
      ovf_q        <= ovf_d;
    end
  end

  assign fifo_rd_en     = pop_c;
  assign link_valid     = link_valid_q;
  assign link_data      = link_data_q;
  assign credit_count   = credit_q;
  assign sent_count     = sent_q;
  assign err_credit_ovf = ovf_q;

endmodule
